// File: rtl/strobe_sequencer.sv
// rtl/strobe_sequencer.sv - trigger-to-strobe scheduler: delay, strobe pulse, holdoff
// Each accepted trigger edge snapshots its timing so later input changes cannot disturb it.
module strobe_sequencer #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MISS_W      = 16
) (
  input  logic              clk48,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              trig_in,
  input  logic [CNT_W-1:0]  delay_cycles,
  input  logic [CNT_W-1:0]  width_cycles,
  input  logic [CNT_W-1:0]  holdoff_cycles,
  output logic              strobe_out,
  output logic              busy,
  output logic [MISS_W-1:0] missed_cnt
);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE, HOLDOFF} state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

  state_t                 state;
  logic [CNT_W-1:0]       counter;
  logic [CNT_W-1:0]       delay_s;
  logic [CNT_W-1:0]       width_s;
  logic [CNT_W-1:0]       holdoff_s;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   trig_rise;

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign trig_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      delay_s    <= '0;
      width_s    <= '0;
      holdoff_s  <= '0;
      strobe_out <= 1'b0;
      busy       <= 1'b0;
      missed_cnt <= '0;
    end else begin
      // An edge landing on the cycle we return to IDLE still sees a busy FSM.
      if (trig_rise && enable && (state != IDLE) && (missed_cnt != '1))
        missed_cnt <= missed_cnt + MISS_ONE;

      if (!enable) begin
        state      <= IDLE;
        counter    <= '0;
        strobe_out <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trig_rise) begin
              delay_s   <= delay_cycles;
              width_s   <= width_cycles;
              holdoff_s <= holdoff_cycles;
              counter   <= '0;
              busy      <= 1'b1;
              state     <= DELAY;
            end
          end
          DELAY: begin
            if (counter == delay_s) begin
              counter <= '0;
              if (width_s != '0) begin
                state      <= PULSE;
                strobe_out <= 1'b1;
              end else begin
                state <= HOLDOFF;
              end
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          PULSE: begin
            if (counter == width_s - CNT_ONE) begin
              counter    <= '0;
              strobe_out <= 1'b0;
              state      <= HOLDOFF;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          HOLDOFF: begin
            if (counter == holdoff_s) begin
              counter <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          default: begin
            state      <= IDLE;
            counter    <= '0;
            strobe_out <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_strobe_sequencer.sv
// tb/tb_strobe_sequencer.sv - scoreboard bench for strobe_sequencer
module tb_strobe_sequencer;

  localparam int CNT_W       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int MISS_W      = 4;

  logic              clk48 = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              trig_in;
  logic [CNT_W-1:0]  delay_cycles;
  logic [CNT_W-1:0]  width_cycles;
  logic [CNT_W-1:0]  holdoff_cycles;
  logic              strobe_out;
  logic              busy;
  logic [MISS_W-1:0] missed_cnt;

  strobe_sequencer #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .MISS_W(MISS_W)) dut (
    .clk48          (clk48),
    .rst_n          (rst_n),
    .enable         (enable),
    .trig_in        (trig_in),
    .delay_cycles   (delay_cycles),
    .width_cycles   (width_cycles),
    .holdoff_cycles (holdoff_cycles),
    .strobe_out     (strobe_out),
    .busy           (busy),
    .missed_cnt     (missed_cnt)
  );

  always #5 clk48 = ~clk48;

  // cyc = number of the most recent rising edge
  int cyc = 0;
  always @(posedge clk48) cyc++;

  typedef struct {
    int start;
    int width;
  } pulse_t;

  pulse_t exp_q[$];
  int     checks = 0;
  int     fails  = 0;
  logic   s_prev = 1'b0;
  int     s_start = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each completed strobe pulse is matched against the next expectation.
  always @(negedge clk48) begin
    if (strobe_out && !s_prev) s_start = cyc;
    if (!strobe_out && s_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: got pulse at %0d width %0d, expected none", s_start, cyc - s_start);
      end else begin
        pulse_t e;
        e = exp_q.pop_front();
        check("pulse_start", s_start, e.start);
        check("pulse_width", cyc - s_start, e.width);
      end
    end
    s_prev = strobe_out;
  end

  task automatic expect_pulse(input int start, input int width);
    pulse_t e;
    e.start = start;
    e.width = width;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk48);
  endtask

  // Returns T, the edge at which the synchronized rise is sampled.
  task automatic trig_pulse(output int t);
    int n;
    n = cyc;
    trig_in = 1'b1;
    @(negedge clk48);
    trig_in = 1'b0;
    t = n + SYNC_STAGES + 1;
  endtask

  task automatic set_timing(input int d, input int w, input int h);
    delay_cycles   = CNT_W'(d);
    width_cycles   = CNT_W'(w);
    holdoff_cycles = CNT_W'(h);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk48);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    rst_n   = 1'b0;
    enable  = 1'b0;
    trig_in = 1'b0;
    set_timing(0, 0, 0);
    repeat (3) @(negedge clk48);
    check("reset_strobe", int'(strobe_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_missed", int'(missed_cnt), 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk48);

    // Basic sequence: strobe T+11..T+14, IDLE again at T+21
    set_timing(10, 4, 5);
    trig_pulse(t);
    expect_pulse(t + 11, 4);
    wait_until(t + 1);
    check("t1_busy_high", int'(busy), 1);
    wait_until(t + 20);
    check("t1_busy_before_idle", int'(busy), 1);
    wait_until(t + 21);
    check("t1_busy_idle", int'(busy), 0);

    // Zero delay, one-cycle strobe
    set_timing(0, 1, 2);
    trig_pulse(t);
    expect_pulse(t + 1, 1);
    wait_until(t + 5);
    check("t2a_busy_idle", int'(busy), 0);

    // Zero width: no strobe, busy still cycles
    set_timing(3, 0, 4);
    trig_pulse(t);
    wait_until(t + 1);
    check("t2b_busy_high", int'(busy), 1);
    wait_until(t + 8);
    check("t2b_busy_late", int'(busy), 1);
    wait_until(t + 9);
    check("t2b_busy_idle", int'(busy), 0);

    // Edge on the very cycle the FSM returns to IDLE is rejected
    set_timing(1, 1, 1);
    trig_pulse(t);
    expect_pulse(t + 2, 1);
    wait_until(t + 2);
    trig_pulse(t2);
    wait_until(t2);
    check("t2c_missed", int'(missed_cnt), 1);
    wait_until(t2 + 2);
    check("t2c_stays_idle", int'(busy), 0);

    // Three edges 3 cycles apart during a long delay
    do_reset();
    set_timing(20, 2, 2);
    trig_pulse(t);
    expect_pulse(t + 21, 2);
    repeat (2) @(negedge clk48);
    for (int i = 0; i < 2; i++) begin
      trig_pulse(t2);
      repeat (2) @(negedge clk48);
    end
    wait_until(t + 25);
    check("t3_busy_late", int'(busy), 1);
    wait_until(t + 26);
    check("t3_busy_idle", int'(busy), 0);
    check("t3_missed", int'(missed_cnt), 2);

    // enable dropped mid-pulse, then normal re-trigger
    do_reset();
    set_timing(2, 10, 3);
    trig_pulse(t);
    expect_pulse(t + 3, 4);
    wait_until(t + 6);
    enable = 1'b0;
    wait_until(t + 7);
    check("t4_strobe_abort", int'(strobe_out), 0);
    check("t4_busy_abort", int'(busy), 0);
    enable = 1'b1;
    set_timing(1, 3, 1);
    trig_pulse(t);
    expect_pulse(t + 2, 3);
    wait_until(t + 6);
    check("t4_busy_retrig", int'(busy), 1);
    wait_until(t + 7);
    check("t4_busy_idle", int'(busy), 0);

    // Reset during DELAY
    do_reset();
    set_timing(20, 2, 2);
    trig_pulse(t);
    repeat (1) @(negedge clk48);
    trig_pulse(t2);
    wait_until(t + 8);
    check("t5_missed_pre", int'(missed_cnt), 1);
    check("t5_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    wait_until(t + 9);
    check("t5_rst_strobe", int'(strobe_out), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_missed", int'(missed_cnt), 0);
    rst_n = 1'b1;
    set_timing(4, 2, 1);
    trig_pulse(t);
    expect_pulse(t + 5, 2);
    wait_until(t + 9);
    check("t5_busy_idle", int'(busy), 0);

    // Saturating missed count; delay input changed mid-DELAY
    do_reset();
    set_timing(200, 2, 2);
    trig_pulse(t);
    expect_pulse(t + 201, 2);
    wait_until(t + 1);
    delay_cycles = CNT_W'(5);
    for (int i = 0; i < 20; i++) begin
      trig_pulse(t2);
      repeat (2) @(negedge clk48);
    end
    wait_until(t + 100);
    check("t6_missed_sat", int'(missed_cnt), 15);
    check("t6_strobe_in_delay", int'(strobe_out), 0);
    wait_until(t + 206);
    check("t6_busy_idle", int'(busy), 0);
    check("t6_missed_hold", int'(missed_cnt), 15);

    repeat (5) @(negedge clk48);
    check("pulses_outstanding", exp_q.size(), 0);
    check("strobe_final", int'(strobe_out), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
